memory_serial_issue: RTL and testbench

Parametrised in-order memory-stage issue unit for the multi-issue pipeline. It accepts a bundle of LANES memory ops from execute and squashes every op younger than the first excepting lane. It issues the surviving loads and stores one at a time onto the single data bus, formatting store data and strobes, and extracting and extending load data. It returns the bundle's results to writeback, holding the pipeline via `in_ready` while transactions are outstanding.

---
 rtl/memory_serial_issue.sv | 265 ++++++++++++++++++++++++++
 tb/tb_memory_serial_issue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_serial_issue.sv
// In-order memory-stage issue unit: squashes lanes at and below the first exception point, then
// issues surviving ops one at a time onto a single data bus. Optional macro: MEMORY_MISALIGN_CHECK_EN.
module memory_serial_issue #(
  parameter int LANES = 2,
  parameter int AW    = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES-1:0]    in_op,
  input  logic [LANES-1:0]    in_load,
  input  logic [LANES-1:0]    in_store,
  input  logic [LANES-1:0]    in_unsigned,
  input  logic [2*LANES-1:0]  in_size,
  input  logic [LANES*AW-1:0] in_addr,
  input  logic [LANES*32-1:0] in_wdata,
  input  logic [LANES-1:0]    in_exc,
  input  logic                flush,
  output logic                dreq_valid,
  output logic [AW-1:0]       dreq_addr,
  output logic [1:0]          dreq_size,
  output logic [3:0]          dreq_strobe,
  output logic [31:0]         dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [31:0]         dresp_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*32-1:0] out_rdata,
  output logic [LANES-1:0]    out_squash,
  output logic [LANES-1:0]    out_adel,
  output logic [LANES-1:0]    out_ades,
  output logic                out_excp
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  drain_req_q, drain_req_d;
  logic [LANES-1:0]      pend_q, pend_d;
  logic [LANES-1:0]      squash_q, squash_d;
  logic [LANES-1:0]      adel_q, adel_d;
  logic [LANES-1:0]      ades_q, ades_d;
  logic                  excp_q, excp_d;
  logic [LANES*32-1:0]   rdata_q, rdata_d;
  logic [LANES-1:0]      load_q, load_d;
  logic [LANES-1:0]      store_q, store_d;
  logic [LANES-1:0]      uns_q, uns_d;
  logic [2*LANES-1:0]    size_q, size_d;
  logic [LANES*AW-1:0]   addr_q, addr_d;
  logic [LANES*32-1:0]   wdata_q, wdata_d;

  logic [LANES-1:0]      squash_new, adel_new, ades_new;
  logic [LANES-1:0]      pend_new, pend_left, cur_oh;
  logic [LW-1:0]         cur;
  logic [AW-1:0]         cur_addr;
  logic [1:0]            cur_size;
  logic [31:0]           cur_wdata;
  logic [31:0]           load_ext;
  logic                  complete;

  function automatic logic [LW-1:0] top_lane(input logic [LANES-1:0] m);
    top_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) top_lane = LW'(i);
    end
  endfunction

  // Right-justify the addressed byte/half and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] ofs,
                                              input logic [1:0] size, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = raw >> {ofs, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'd0:    extend_load = uns ? {24'd0, sh[7:0]} : 32'(b);
      2'd1:    extend_load = uns ? {16'd0, sh[15:0]} : 32'(h);
      default: extend_load = sh;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] ofs);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    store_strobe = base << ofs;
  endfunction

`ifdef MEMORY_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
    if (size == 2'd1)      misaligned = ofs[0];
    else if (size >= 2'd2) misaligned = (ofs != 2'd0);
    else                   misaligned = 1'b0;
  endfunction
`endif

  // Exception point decode: everything at or below the oldest excepting lane is squashed.
  always_comb begin
    logic older;
`ifdef MEMORY_MISALIGN_CHECK_EN
    logic mis;
    mis = 1'b0;
`endif
    older      = 1'b0;
    squash_new = '0;
    adel_new   = '0;
    ades_new   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
`ifdef MEMORY_MISALIGN_CHECK_EN
      mis         = in_op[i] && misaligned(in_size[2*i +: 2], in_addr[AW*i +: 2]);
      adel_new[i] = mis && in_load[i] && !older;
      ades_new[i] = mis && in_store[i] && !older;
      older       = older | in_exc[i] | mis;
`else
      older       = older | in_exc[i];
`endif
      squash_new[i] = older;
    end
  end

  assign pend_new  = in_op & ~squash_new;
  assign cur       = top_lane(pend_q);
  assign cur_addr  = addr_q[AW*cur +: AW];
  assign cur_size  = size_q[2*cur +: 2];
  assign cur_wdata = wdata_q[32*cur +: 32];
  assign load_ext  = extend_load(dresp_data, cur_addr[1:0], cur_size, uns_q[cur]);

  always_comb begin
    cur_oh      = '0;
    cur_oh[cur] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    drain_req_d = drain_req_q;
    pend_d      = pend_q;
    squash_d    = squash_q;
    adel_d      = adel_q;
    ades_d      = ades_q;
    excp_d      = excp_q;
    rdata_d     = rdata_q;
    load_d      = load_q;
    store_d     = store_q;
    uns_d       = uns_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    complete    = 1'b0;
    pend_left   = pend_q & ~cur_oh;

    case (state_q)
      S_IDLE: begin
        if (!flush && in_valid) begin
          load_d   = in_load;
          store_d  = in_store;
          uns_d    = in_unsigned;
          size_d   = in_size;
          addr_d   = in_addr;
          wdata_d  = in_wdata;
          squash_d = squash_new;
          adel_d   = adel_new;
          ades_d   = ades_new;
          excp_d   = |squash_new;
          rdata_d  = '0;
          pend_d   = pend_new;
          state_d  = (|pend_new) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (flush) begin
          if (dresp_addr_ok && dresp_data_ok) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_DRAIN;
            drain_req_d = !dresp_addr_ok;
          end
        end else if (dresp_addr_ok) begin
          if (dresp_data_ok) complete = 1'b1;
          else               state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d     = dresp_data_ok ? S_IDLE : S_DRAIN;
          drain_req_d = 1'b0;
        end else if (dresp_data_ok) begin
          complete = 1'b1;
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // The abandoned request must still be accepted and answered before the bus is free.
        if (drain_req_q) begin
          if (dresp_addr_ok) begin
            drain_req_d = 1'b0;
            if (dresp_data_ok) state_d = S_IDLE;
          end
        end else if (dresp_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      pend_d = pend_left;
      if (load_q[cur]) rdata_d[32*cur +: 32] = load_ext;
      state_d = (|pend_left) ? S_REQ : S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      drain_req_q <= 1'b0;
      pend_q      <= '0;
      squash_q    <= '0;
      adel_q      <= '0;
      ades_q      <= '0;
      excp_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_req_q <= drain_req_d;
      pend_q      <= pend_d;
      squash_q    <= squash_d;
      adel_q      <= adel_d;
      ades_q      <= ades_d;
      excp_q      <= excp_d;
      rdata_q     <= rdata_d;
    end
    load_q  <= load_d;
    store_q <= store_d;
    uns_q   <= uns_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Bus request fields are forced to zero whenever no request is presented.
  assign in_ready    = (state_q == S_IDLE);
  assign dreq_valid  = (state_q == S_REQ) || ((state_q == S_DRAIN) && drain_req_q);
  assign dreq_addr   = dreq_valid ? cur_addr : '0;
  assign dreq_size   = dreq_valid ? cur_size : 2'd0;
  assign dreq_strobe = (dreq_valid && store_q[cur]) ? store_strobe(cur_size, cur_addr[1:0]) : 4'd0;
  assign dreq_data   = (dreq_valid && store_q[cur]) ? (cur_wdata << {cur_addr[1:0], 3'b000}) : 32'd0;
  assign out_valid   = (state_q == S_DONE);
  assign out_rdata   = rdata_q;
  assign out_squash  = squash_q;
  assign out_adel    = adel_q;
  assign out_ades    = ades_q;
  assign out_excp    = excp_q;

endmodule

// File: tb/tb_memory_serial_issue.sv
// Directed bench for memory_serial_issue: vector table with a zero-wait bus responder,
// plus hand sequences for request hold, flush drain and mid-transaction reset.
module tb_memory_serial_issue;
  localparam int LANES = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0, in_load = '0, in_store = '0, in_unsigned = '0, in_exc = '0;
  logic [3:0]    in_size = '0;
  logic [63:0]   in_addr = '0, in_wdata = '0;
  logic          flush = 1'b0;
  logic          dreq_valid;
  logic [31:0]   dreq_addr;
  logic [1:0]    dreq_size;
  logic [3:0]    dreq_strobe;
  logic [31:0]   dreq_data;
  logic          dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
  logic [31:0]   dresp_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_rdata;
  logic [1:0]    out_squash, out_adel, out_ades;
  logic          out_excp;

  always #5 clk = ~clk;

  memory_serial_issue #(.LANES(LANES), .AW(AW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_load(in_load), .in_store(in_store), .in_unsigned(in_unsigned),
    .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata), .in_exc(in_exc),
    .flush(flush), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_rdata(out_rdata), .out_squash(out_squash),
    .out_adel(out_adel), .out_ades(out_ades), .out_excp(out_excp)
  );

  // Field order: stimulus, then expected bus requests in issue order, then expected results.
  typedef struct packed {
    logic [1:0]  op, ld, st, uns, exc;
    logic [3:0]  size;
    logic [63:0] addr, wdata;
    logic [31:0] resp;
    logic [7:0]  nreq;
    logic [31:0] ea0, ed0;
    logic [3:0]  es0;
    logic [31:0] ea1, ed1;
    logic [3:0]  es1;
    logic [7:0]  lat;
    logic [63:0] rdata;
    logic [1:0]  squash, adel, ades;
    logic        excp;
  } vec_t;

  vec_t vecs [9];
  int n_applied = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] ld, input logic [1:0] st,
                       input logic [1:0] uns, input logic [1:0] exc, input logic [3:0] size,
                       input logic [63:0] addr, input logic [63:0] wdata);
    @(negedge clk);
    in_op = op; in_load = ld; in_store = st; in_unsigned = uns; in_exc = exc;
    in_size = size; in_addr = addr; in_wdata = wdata;
    in_valid = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, nreq;
    bit seen, gave;
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    logic [3:0]  rs [2];
    lat = 0; nreq = 0; seen = 0; gave = 0;
    for (int k = 0; k < 2; k++) begin ra[k] = '0; rd[k] = '0; rs[k] = '0; end
    drive(v.op, v.ld, v.st, v.uns, v.exc, v.size, v.addr, v.wdata);
    check($sformatf("v%0d_in_ready", idx), in_ready, 1'b1);
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      if (out_valid) begin
        seen = 1;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      end else if (gave) begin
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b1; dresp_data = v.resp; gave = 0;
      end else if (dreq_valid) begin
        if (nreq < 2) begin ra[nreq] = dreq_addr; rd[nreq] = dreq_data; rs[nreq] = dreq_strobe; end
        nreq++;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0; gave = 1;
      end else begin
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      end
    end
    check($sformatf("v%0d_out_valid_seen", idx), 64'(seen), 64'd1);
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d_nreq", idx), 64'(nreq), 64'(v.nreq));
    check($sformatf("v%0d_req0_addr", idx), ra[0], v.ea0);
    check($sformatf("v%0d_req0_data", idx), rd[0], v.ed0);
    check($sformatf("v%0d_req0_strobe", idx), rs[0], v.es0);
    check($sformatf("v%0d_req1_addr", idx), ra[1], v.ea1);
    check($sformatf("v%0d_req1_data", idx), rd[1], v.ed1);
    check($sformatf("v%0d_req1_strobe", idx), rs[1], v.es1);
    check($sformatf("v%0d_rdata", idx), out_rdata, v.rdata);
    check($sformatf("v%0d_squash", idx), out_squash, v.squash);
    check($sformatf("v%0d_excp", idx), out_excp, v.excp);
    check($sformatf("v%0d_adel", idx), out_adel, v.adel);
    check($sformatf("v%0d_ades", idx), out_ades, v.ades);
    @(negedge clk);
    check($sformatf("v%0d_hold_valid", idx), out_valid, 1'b1);
    check($sformatf("v%0d_hold_rdata", idx), out_rdata, v.rdata);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d_back_idle", idx), in_ready, 1'b1);
    check($sformatf("v%0d_valid_drop", idx), out_valid, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // lb 0x1003 + sw 0xDEADBEEF@0x2000
    vecs[0] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 4'b0010, 64'h00001003_00002000, 64'h00000000_DEADBEEF,
                32'h80000000, 8'd2, 32'h1003, 32'h0, 4'h0, 32'h2000, 32'hDEADBEEF, 4'hF,
                8'd5, 64'hFFFFFF80_00000000, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[1] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0100, 64'h00003002_00000000, 64'h00001234_00000000,
                32'h0, 8'd1, 32'h3002, 32'h12340000, 4'hC, 32'h0, 32'h0, 4'h0,
                8'd3, 64'h0, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[2] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 4'b1010, 64'h00000100_00000200, 64'h0,
                32'h0, 8'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                8'd1, 64'h0, 2'b11, 2'b00, 2'b00, 1'b1};
`ifdef MEMORY_MISALIGN_CHECK_EN
    vecs[3] = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 4'b1000, 64'h00004002_00000010, 64'h0,
                32'h11223344, 8'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                8'd1, 64'h0, 2'b11, 2'b10, 2'b00, 1'b1};
`else
    vecs[3] = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 4'b1000, 64'h00004002_00000010, 64'h0,
                32'h11223344, 8'd2, 32'h4002, 32'h0, 4'h0, 32'h10, 32'h0, 4'h0,
                8'd5, 64'h00001122_00000044, 2'b00, 2'b00, 2'b00, 1'b0};
`endif
    vecs[4] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0001, 64'h00000000_00000022, 64'h0,
                32'h80017FFF, 8'd1, 32'h22, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                8'd3, 64'h00000000_FFFF8001, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[5] = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b00, 4'b0100, 64'h00000006_00000101, 64'h00000000_1234565A,
                32'hABCD0000, 8'd2, 32'h6, 32'h0, 4'h0, 32'h101, 32'h34565A00, 4'b0010,
                8'd5, 64'h0000ABCD_00000000, 2'b00, 2'b00, 2'b00, 1'b0};
    vecs[6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 4'b1000, 64'h00000050_00000000, 64'hCAFEF00D_00000000,
                32'h0, 8'd1, 32'h50, 32'hCAFEF00D, 4'hF, 32'h0, 32'h0, 4'h0,
                8'd3, 64'h0, 2'b01, 2'b00, 2'b00, 1'b1};
    vecs[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 64'h0, 64'h0,
                32'h0, 8'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                8'd1, 64'h0, 2'b00, 2'b00, 2'b00, 1'b0};
`ifdef MEMORY_MISALIGN_CHECK_EN
    vecs[8] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 4'b1000, 64'h00000061_00000000, 64'hA1B2C3D4_00000000,
                32'h0, 8'd0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0,
                8'd1, 64'h0, 2'b11, 2'b00, 2'b10, 1'b1};
`else
    vecs[8] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 4'b1000, 64'h00000061_00000000, 64'hA1B2C3D4_00000000,
                32'h0, 8'd1, 32'h61, 32'hB2C3D400, 4'b1110, 32'h0, 32'h0, 4'h0,
                8'd3, 64'h0, 2'b00, 2'b00, 2'b00, 1'b0};
`endif

    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_dreq_valid", dreq_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rdata", out_rdata, 64'h0);
    check("rst_squash", out_squash, 2'b00);
    check("rst_excp", out_excp, 1'b0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Request held until addr_ok, then addr_ok+data_ok together skip WAIT.
    drive(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000, 64'h00000009_00000000, 64'h0);
    @(negedge clk); in_valid = 1'b0;
    check("hold_valid0", dreq_valid, 1'b1);
    check("hold_addr0", dreq_addr, 32'h9);
    check("hold_strobe0", dreq_strobe, 4'h0);
    check("hold_size0", dreq_size, 2'd0);
    @(negedge clk);
    check("hold_valid1", dreq_valid, 1'b1);
    check("hold_addr1", dreq_addr, 32'h9);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h0000F000;
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    check("same_cycle_out_valid", out_valid, 1'b1);
    check("same_cycle_rdata", out_rdata, 64'hFFFFFFF0_00000000);
    check("same_cycle_no_req", dreq_valid, 1'b0);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("same_cycle_idle", in_ready, 1'b1);

    // Flush during WAIT with data_ok three cycles late.
    drive(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 4'b1010, 64'h00000100_00000200, 64'h0);
    @(negedge clk); in_valid = 1'b0;
    check("flush_req_valid", dreq_valid, 1'b1);
    check("flush_req_addr", dreq_addr, 32'h100);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("drain%0d_in_ready", c), in_ready, 1'b0);
      check($sformatf("drain%0d_dreq_valid", c), dreq_valid, 1'b0);
      check($sformatf("drain%0d_out_valid", c), out_valid, 1'b0);
      @(negedge clk);
    end
    dresp_data_ok = 1'b1; dresp_data = 32'h55555555;
    check("drain_dataok_in_ready", in_ready, 1'b0);
    @(negedge clk);
    dresp_data_ok = 1'b0;
    check("drain_done_in_ready", in_ready, 1'b1);
    check("drain_done_out_valid", out_valid, 1'b0);
    check("drain_done_dreq_valid", dreq_valid, 1'b0);
    @(negedge clk);
    check("drain_lane0_not_issued", dreq_valid, 1'b0);
    check("drain_no_out_valid", out_valid, 1'b0);

    // Reset asserted while a request is pending on the bus.
    drive(2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 4'b1010, 64'h00000300_00000400, 64'h0);
    @(negedge clk); in_valid = 1'b0;
    check("rreq_valid", dreq_valid, 1'b1);
    check("rreq_squash", out_squash, 2'b01);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rreq_after_dreq_valid", dreq_valid, 1'b0);
    check("rreq_after_dreq_addr", dreq_addr, 32'h0);
    check("rreq_after_in_ready", in_ready, 1'b1);
    check("rreq_after_out_valid", out_valid, 1'b0);
    check("rreq_after_squash", out_squash, 2'b00);
    check("rreq_after_excp", out_excp, 1'b0);
    check("rreq_after_rdata", out_rdata, 64'h0);
    @(negedge clk);
    check("rreq_stays_quiet", dreq_valid, 1'b0);

    run_vec(9, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
    $finish;
  end

endmodule
